// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver plus a scancode decoder that turns make and break codes into key-held levels.
// Frames are 11 bits: start(0), 8 data LSB first, odd parity, stop(1). Bits are sampled on PS/2 clock falls.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       raw_left,
    output logic       raw_right,
    output logic       raw_down,
    output logic       raw_rotate,
    output logic       raw_drop,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_prev;
    logic          fall, bit_in;

    state_t        state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par_bit, par_bit_n;
    logic [TW-1:0] tcnt;
    logic          timeout, accept, reject;

    logic          ext, brk;

    // Both PS/2 lines are asynchronous; nothing downstream sees them before two flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '0;
            dat_sync <= '0;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall    = clk_prev & ~clk_sync[1];
    assign bit_in  = dat_sync[1];
    assign timeout = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES));

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_bit_n = par_bit;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !bit_in) begin
                    state_n   = DATA;
                    bit_cnt_n = 3'd0;
                    shreg_n   = 8'h00;
                end
            end
            DATA: begin
                if (fall) begin
                    shreg_n   = {bit_in, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_n = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_bit_n = bit_in;
                    state_n   = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    // Data plus parity must hold an odd number of ones.
                    if (bit_in && ^{shreg, par_bit})
                        accept = 1'b1;
                    else
                        reject = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (timeout) begin
            state_n   = IDLE;
            reject    = 1'b1;
            bit_cnt_n = 3'd0;
            shreg_n   = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            par_bit    <= 1'b0;
            tcnt       <= '0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            par_bit    <= par_bit_n;
            tcnt       <= (fall || state_n == IDLE) ? '0 : tcnt + 1'b1;
            byte_valid <= accept;
            frame_err  <= reject;
            if (accept)
                byte_data <= shreg;
        end
    end

    // Decoder sees only accepted bytes, so outputs land one cycle after byte_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext        <= 1'b0;
            brk        <= 1'b0;
            raw_left   <= 1'b0;
            raw_right  <= 1'b0;
            raw_down   <= 1'b0;
            raw_rotate <= 1'b0;
            raw_drop   <= 1'b0;
        end else if (byte_valid) begin
            if (byte_data == 8'hE0) begin
                ext <= 1'b1;
            end else if (byte_data == 8'hF0) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (ext && byte_data == 8'h6B) raw_left   <= ~brk;
                if (ext && byte_data == 8'h74) raw_right  <= ~brk;
                if (ext && byte_data == 8'h72) raw_down   <= ~brk;
                if (ext && byte_data == 8'h75) raw_rotate <= ~brk;
                if (!ext && byte_data == 8'h29) raw_drop  <= ~brk;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed and randomized PS/2 frames checked against a table-driven model of the key map.
module tb_ps2_key_decoder;

    localparam int TO = 200;
    localparam int H  = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       raw_left, raw_right, raw_down, raw_rotate, raw_drop;
    logic       byte_valid, frame_err;
    logic [7:0] byte_data;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .raw_left(raw_left), .raw_right(raw_right), .raw_down(raw_down),
        .raw_rotate(raw_rotate), .raw_drop(raw_drop),
        .byte_valid(byte_valid), .byte_data(byte_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int ncmp = 0, nfail = 0;
    int cyc = 0;
    int bv_cnt = 0, fe_cnt = 0, bv_cyc = 0, fe_cyc = 0, stop_cyc = 0;
    int bv_byte = 0, raw_at_bv = 0, raw_after = 0;
    logic prev_bv = 1'b0;

    // Reference model: key index 0..4 = left,right,down,rotate,drop
    bit       m_ext = 0, m_brk = 0;
    bit [4:0] m_keys = '0;
    int       m_last = 0;

    function automatic int raws();
        return {27'd0, raw_drop, raw_rotate, raw_down, raw_right, raw_left};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (prev_bv) raw_after = raws();
        if (byte_valid) begin
            bv_cnt++;
            bv_cyc    = cyc;
            bv_byte   = int'(byte_data);
            raw_at_bv = raws();
        end
        if (frame_err) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
        prev_bv = byte_valid;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_byte(input int b);
        int idx;
        if (b == 'hE0) m_ext = 1;
        else if (b == 'hF0) m_brk = 1;
        else begin
            idx = -1;
            if (m_ext) begin
                case (b)
                    'h6B: idx = 0;
                    'h74: idx = 1;
                    'h72: idx = 2;
                    'h75: idx = 3;
                    default: idx = -1;
                endcase
            end else if (b == 'h29) idx = 4;
            if (idx >= 0) m_keys[idx] = !m_brk;
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the first n bits of an 11-bit frame; records when the last falling edge was driven.
    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = fr[i];
            wait_cyc(H);
            ps2_clk = 1'b0;
            stop_cyc = cyc;
            wait_cyc(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic do_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int bv0, fe0, prev_keys;
        bit ok;
        bv0 = bv_cnt;
        fe0 = fe_cnt;
        prev_keys = int'(m_keys);
        ok = !bad_par && !bad_stop;
        send_bits(mk_frame(b, bad_par, bad_stop), 11);
        wait_cyc(8);
        chk("bv_count", bv_cnt - bv0, int'(ok));
        chk("fe_count", fe_cnt - fe0, int'(!ok));
        if (ok) begin
            model_byte(int'(b));
            m_last = int'(b);
            chk("bv_latency", bv_cyc - stop_cyc, 3);
            chk("bv_byte", bv_byte, int'(b));
            chk("raw_at_bv", raw_at_bv, prev_keys);
            chk("raw_after_bv", raw_after, int'(m_keys));
        end else begin
            chk("fe_latency", fe_cyc - stop_cyc, 3);
        end
        chk("byte_data_held", int'(byte_data), m_last);
        chk("raws", raws(), int'(m_keys));
    endtask

    function automatic logic [7:0] pick_byte();
        logic [7:0] tbl [8] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h72, 8'h75, 8'h29, 8'hE1};
        int k;
        k = $urandom_range(0, 9);
        if (k >= 8) return 8'($urandom_range(0, 255));
        return tbl[k];
    endfunction

    initial begin
        int bv0, fe0, lat;
        // Reset state
        wait_cyc(4);
        chk("rst_raws", raws(), 0);
        chk("rst_bv", int'(byte_valid), 0);
        chk("rst_fe", int'(frame_err), 0);
        chk("rst_byte", int'(byte_data), 0);
        rst = 1'b0;
        wait_cyc(4);

        // E0 6B -> left held
        do_frame(8'hE0, 0, 0);
        do_frame(8'h6B, 0, 0);
        chk("left_set", raws(), 5'b00001);
        // E0 F0 6B -> left released
        do_frame(8'hE0, 0, 0);
        do_frame(8'hF0, 0, 0);
        do_frame(8'h6B, 0, 0);
        chk("left_clr", raws(), 0);
        // 29 then F0 29
        do_frame(8'h29, 0, 0);
        chk("drop_pulse", int'(raw_drop), 1);
        do_frame(8'hF0, 0, 0);
        do_frame(8'h29, 0, 0);
        chk("drop_clr", int'(raw_drop), 0);
        // Bad parity and bad stop
        do_frame(8'h29, 1, 0);
        chk("badpar_drop", int'(raw_drop), 0);
        do_frame(8'h29, 0, 1);

        // Timeout on a 5-bit partial frame, then a good 0x29
        bv0 = bv_cnt;
        fe0 = fe_cnt;
        send_bits(mk_frame(8'h29, 0, 0), 5);
        for (int i = 0; i < 2 * TO && fe_cnt == fe0; i++) wait_cyc(1);
        wait_cyc(2);
        chk("to_fe_count", fe_cnt - fe0, 1);
        chk("to_bv_count", bv_cnt - bv0, 0);
        lat = fe_cyc - stop_cyc;
        chk("to_latency_window", int'(lat >= TO && lat <= TO + 8), 1);
        do_frame(8'h29, 0, 0);
        chk("to_then_drop", int'(raw_drop), 1);

        // Simultaneous keys: rotate + drop, then release rotate
        do_frame(8'hE0, 0, 0);
        do_frame(8'h75, 0, 0);
        chk("rot_and_drop", raws(), 5'b11000);
        do_frame(8'hE0, 0, 0);
        do_frame(8'hF0, 0, 0);
        do_frame(8'h75, 0, 0);
        chk("drop_only", raws(), 5'b10000);
        // Unmapped codes: non-extended 6B, E1, repeated make
        do_frame(8'h6B, 0, 0);
        do_frame(8'hE1, 0, 0);
        do_frame(8'h29, 0, 0);

        // Reset mid-frame while down is held
        do_frame(8'hE0, 0, 0);
        do_frame(8'h72, 0, 0);
        chk("down_held", int'(raw_down), 1);
        bv0 = bv_cnt;
        fe0 = fe_cnt;
        send_bits(mk_frame(8'h6B, 0, 0), 6);
        rst = 1'b1;
        wait_cyc(3);
        chk("midrst_raws", raws(), 0);
        chk("midrst_byte", int'(byte_data), 0);
        rst = 1'b0;
        m_keys = '0;
        m_ext = 0;
        m_brk = 0;
        m_last = 0;
        wait_cyc(3 * TO);
        chk("midrst_no_bv", bv_cnt - bv0, 0);
        chk("midrst_no_fe", fe_cnt - fe0, 0);
        do_frame(8'hE0, 0, 0);
        do_frame(8'h6B, 0, 0);
        chk("after_rst_left", raws(), 5'b00001);

        // Randomized frames against the model
        for (int n = 0; n < 60; n++)
            do_frame(pick_byte(), $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
